// File: rtl/mul_pkg.sv
// Shared definitions for the product accumulator: default widths and FSM encoding.
package mul_pkg;

  localparam int unsigned PROD_W_DEF = 32;
  localparam int unsigned ACC_W_DEF  = 40;
  localparam int unsigned LEN_W_DEF  = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StAcc  = ACC,
    StDone = DONE
  } state_e;

endpackage

// File: rtl/mul_accumulator.sv
// Streaming MAC reduction: sums `len` unsigned products from the multiplier into a
// wide accumulator and presents the total (plus a sticky carry-out flag) on a
// valid/ready output port.
module mul_accumulator
  import mul_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [LEN_W-1:0]   count_q, count_d;

  // One extra bit captures the carry out of the accumulator MSB.
  logic [ACC_W:0]     prod_ext;
  logic [ACC_W:0]     sum;

  // Zero-extend the product and form the widened sum.
  always_comb begin
    prod_ext              = '0;
    prod_ext[PROD_W-1:0]  = in_prod;
    sum                   = {1'b0, acc_q} + prod_ext;
  end

  // Next-state, accumulator and beat-counter update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = len;
          // An empty job completes immediately with a zero total.
          state_d = (len == '0) ? StDone : StAcc;
        end
      end
      StAcc: begin
        if (in_valid) begin
          acc_d   = sum[ACC_W-1:0];
          ovf_d   = ovf_q | sum[ACC_W];
          count_d = count_q - 1'b1;
          if (count_q == LEN_W'(1)) state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  // Handshake and status outputs decode straight from the state register.
  always_comb begin
    in_ready  = (state_q == StAcc);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    out_acc   = acc_q;
    out_ovf   = ovf_q;
  end

endmodule
